// File: rtl/spmm_pkg.sv
// Shared SpMM types: element/row/CSR field widths and the encoder state enum.
package spmm_pkg;
  localparam int N     = 16;
  localparam int W     = 8;
  localparam int lgN   = $clog2(N);
  localparam int dbLgN = 2 * lgN;

  typedef logic [W-1:0]     data_t;
  typedef data_t [N-1:0]    row_t;
  typedef logic [lgN-1:0]   col_t;
  typedef logic [dbLgN-1:0] ptr_t;
  typedef logic [dbLgN:0]   nnz_t;
  typedef logic [lgN:0]     pop_t;

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, EMIT} state_t;
endpackage

// File: rtl/csr_encoder_if.sv
// Dense-load and CSR-beat signals of csr_encoder; master = encoder, slave = host/consumer side.
interface csr_encoder_if;
  import spmm_pkg::*;

  logic            in_ready;
  logic            in_start;
  row_t [3:0]      in_data;
  logic            lhs_valid;
  logic            lhs_ready;
  logic            lhs_start;
  logic            lhs_last;
  ptr_t [N-1:0]    lhs_ptr;
  col_t [N-1:0]    lhs_col;
  row_t            lhs_data;
  nnz_t            nnz_total;

  modport master (
    output in_ready, lhs_valid, lhs_start, lhs_last, lhs_ptr, lhs_col, lhs_data, nnz_total,
    input  in_start, in_data, lhs_ready
  );

  modport slave (
    input  in_ready, lhs_valid, lhs_start, lhs_last, lhs_ptr, lhs_col, lhs_data, nnz_total,
    output in_start, in_data, lhs_ready
  );
endinterface

// File: rtl/csr_row_compact.sv
// Combinational: packs one row's nonzeros in ascending column order and counts them.
module csr_row_compact
  import spmm_pkg::*;
(
  input  row_t          row_i,
  output col_t [N-1:0]  col_o,
  output row_t          dat_o,
  output pop_t          pop_o
);

  pop_t n;

  always_comb begin
    col_o = '0;
    dat_o = '0;
    n     = '0;
    for (int j = 0; j < N; j++) begin
      if (row_i[j] != '0) begin
        col_o[n[lgN-1:0]] = col_t'(j);
        dat_o[n[lgN-1:0]] = row_i[j];
        n = n + pop_t'(1);
      end
    end
    pop_o = n;
  end

endmodule

// File: rtl/csr_encoder.sv
// Buffers a dense NxN matrix (4 rows/cycle), scans one row per cycle into a flat
// CSR element buffer, then streams N-element beats under valid/ready.
module csr_encoder
  import spmm_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  csr_encoder_if.master bus
);

  state_t state_q, state_d;
  col_t   idx_q, idx_d;     // load block index in LOAD, row index in SCAN
  col_t   beat_q, beat_d;
  nnz_t   cnt_q, cnt_d;
  ptr_t [N-1:0] ptr_q;

  row_t   mat_q  [N];
  col_t   ecol_q [N*N];
  data_t  edat_q [N*N];

  logic   load_we, scan_en, emit, accept;
  col_t   load_row;
  col_t   last_beat;
  nnz_t   cnt_m1;

  col_t [N-1:0] cmp_col;
  row_t         cmp_dat;
  pop_t         cmp_pop;

  ptr_t         wr_addr [N];
  logic [N-1:0] wr_en;
  ptr_t         rd_addr [N];
  col_t [N-1:0] col_o;
  row_t         dat_o;

  csr_row_compact u_compact (
    .row_i (mat_q[idx_q]),
    .col_o (cmp_col),
    .dat_o (cmp_dat),
    .pop_o (cmp_pop)
  );

  assign emit      = (state_q == EMIT);
  assign accept    = emit && bus.lhs_ready;
  assign cnt_m1    = cnt_q - nnz_t'(1);
  // An empty matrix still emits one (all-zero) beat.
  assign last_beat = (cnt_q == '0) ? '0 : col_t'(cnt_m1 >> lgN);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    beat_d   = beat_q;
    cnt_d    = cnt_q;
    load_we  = 1'b0;
    load_row = '0;
    scan_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_start) begin
          load_we = 1'b1;
          cnt_d   = '0;
          beat_d  = '0;
          if (N / 4 > 1) begin
            state_d = LOAD;
            idx_d   = col_t'(1);
          end else begin
            state_d = SCAN;
            idx_d   = '0;
          end
        end
      end
      LOAD: begin
        load_we  = 1'b1;
        load_row = idx_q << 2;
        if (idx_q == col_t'(N / 4 - 1)) begin
          state_d = SCAN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + col_t'(1);
        end
      end
      SCAN: begin
        scan_en = 1'b1;
        cnt_d   = cnt_q + nnz_t'(cmp_pop);
        if (idx_q == col_t'(N - 1)) begin
          state_d = EMIT;
          idx_d   = '0;
          beat_d  = '0;
        end else begin
          idx_d = idx_q + col_t'(1);
        end
      end
      EMIT: begin
        if (accept) begin
          if (beat_q == last_beat) state_d = IDLE;
          else                     beat_d  = beat_q + col_t'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      if (scan_en) ptr_q[idx_q] <= cnt_q[dbLgN-1:0];
    end
  end

  // Only the first popcount slots of the compacted row land in the element buffer.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      wr_addr[j] = ptr_t'(cnt_q + nnz_t'(j));
      wr_en[j]   = scan_en && (pop_t'(j) < cmp_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (load_we) begin
      for (int i = 0; i < 4; i++) mat_q[load_row + col_t'(i)] <= bus.in_data[i];
    end
    for (int j = 0; j < N; j++) begin
      if (wr_en[j]) begin
        ecol_q[wr_addr[j]] <= cmp_col[j];
        edat_q[wr_addr[j]] <= cmp_dat[j];
      end
    end
  end

  // Slots past nnz_total are forced to zero rather than exposing stale buffer contents.
  always_comb begin
    col_o = '0;
    dat_o = '0;
    for (int j = 0; j < N; j++) begin
      rd_addr[j] = {beat_q, col_t'(j)};
      if (emit && (nnz_t'(rd_addr[j]) < cnt_q)) begin
        col_o[j] = ecol_q[rd_addr[j]];
        dat_o[j] = edat_q[rd_addr[j]];
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.lhs_valid = emit;
  assign bus.lhs_start = emit && (beat_q == '0);
  assign bus.lhs_last  = emit && (beat_q == last_beat);
  assign bus.lhs_ptr   = emit ? ptr_q : '0;
  assign bus.nnz_total = emit ? cnt_q : '0;
  assign bus.lhs_col   = col_o;
  assign bus.lhs_data  = dat_o;

endmodule

// File: tb/tb_csr_encoder.sv
// Directed + randomized bench for csr_encoder against a queue-based CSR reference model.
module tb_csr_encoder;
  import spmm_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  csr_encoder_if bus ();
  csr_encoder dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  data_t mat [N][N];
  ptr_t  exp_ptr [N];
  col_t  q_col [$];
  data_t q_dat [$];
  int    nnz;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model();
    nnz = 0;
    q_col.delete();
    q_dat.delete();
    for (int r = 0; r < N; r++) begin
      exp_ptr[r] = ptr_t'(nnz);
      for (int c = 0; c < N; c++) begin
        if (mat[r][c] != 0) begin
          q_col.push_back(col_t'(c));
          q_dat.push_back(mat[r][c]);
          nnz++;
        end
      end
    end
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mat[r][c] = data_t'(v);
  endtask

  task automatic load();
    bus.in_start = 1'b1;
    for (int k = 0; k < N / 4; k++) begin
      for (int i = 0; i < 4; i++)
        for (int c = 0; c < N; c++) bus.in_data[i][c] = mat[4 * k + i][c];
      tick();
      bus.in_start = 1'b0;
    end
    bus.in_data = '0;
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for 3 cycles during beat 1
  task automatic run(input int mode, input string tag);
    int lat, beats, b, hold, guard, idx;
    logic rdy;
    logic [511:0] snap;
    ptr_t [N-1:0] eptr;
    col_t [N-1:0] ecol;
    row_t         edat;
    model();
    for (int r = 0; r < N; r++) eptr[r] = exp_ptr[r];
    chk({tag, "_in_ready_pre"}, bus.in_ready, 1'b1);
    load();
    lat = N / 4;
    while (!bus.lhs_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, N / 4 + N);
    beats = (nnz == 0) ? 1 : (nnz + N - 1) / N;
    b = 0; hold = 0; guard = 0;
    while (b < beats && guard < 2000) begin
      guard++;
      chk({tag, "_valid"}, bus.lhs_valid, 1'b1);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = !(b == 1 && hold < 3);
      endcase
      bus.lhs_ready = rdy;
      if (!rdy) begin
        snap = {bus.lhs_start, bus.lhs_last, bus.nnz_total, bus.lhs_ptr, bus.lhs_col, bus.lhs_data};
        hold++;
        tick();
        chk({tag, "_hold"}, {bus.lhs_start, bus.lhs_last, bus.nnz_total, bus.lhs_ptr,
                             bus.lhs_col, bus.lhs_data}, snap);
      end else begin
        for (int j = 0; j < N; j++) begin
          idx = b * N + j;
          ecol[j] = (idx < nnz) ? q_col[idx] : '0;
          edat[j] = (idx < nnz) ? q_dat[idx] : '0;
        end
        chk({tag, "_start"}, bus.lhs_start, (b == 0));
        chk({tag, "_last"},  bus.lhs_last,  (b == beats - 1));
        chk({tag, "_nnz"},   bus.nnz_total, nnz);
        chk({tag, "_ptr"},   bus.lhs_ptr,   eptr);
        chk({tag, "_col"},   bus.lhs_col,   ecol);
        chk({tag, "_data"},  bus.lhs_data,  edat);
        tick();
        b++;
      end
    end
    chk({tag, "_beats"}, b, beats);
    chk({tag, "_in_ready_post"}, bus.in_ready, 1'b1);
    chk({tag, "_valid_post"}, bus.lhs_valid, 1'b0);
    bus.lhs_ready = 1'b1;
  endtask

  initial begin
    int dens;
    reset = 1'b0;
    bus.in_start  = 1'b0;
    bus.in_data   = '0;
    bus.lhs_ready = 1'b1;
    #2 reset = 1'b1;
    #10;
    chk("rst_in_ready",  bus.in_ready,  1'b1);
    chk("rst_valid",     bus.lhs_valid, 1'b0);
    chk("rst_start",     bus.lhs_start, 1'b0);
    chk("rst_last",      bus.lhs_last,  1'b0);
    chk("rst_ptr",       bus.lhs_ptr,   '0);
    chk("rst_col",       bus.lhs_col,   '0);
    chk("rst_data",      bus.lhs_data,  '0);
    chk("rst_nnz",       bus.nnz_total, '0);
    tick();
    reset = 1'b0;
    tick();

    fill_const(0);
    for (int r = 0; r < N; r++) mat[r][r] = 8'd1;
    run(0, "ident");

    fill_const(0);
    run(0, "zero");

    fill_const(1);
    run(0, "ones");

    fill_const(0);
    for (int c = 0; c < N; c++) begin
      mat[0][c] = 8'd2;
      mat[1][c] = 8'd2;
    end
    mat[5][7] = 8'd9;
    run(0, "sparse2");

    fill_const(1);
    run(2, "ones_bp");

    // abort during SCAN row 8, then a clean identity load
    fill_const(0);
    for (int r = 0; r < N; r++) mat[r][r] = 8'd1;
    load();
    for (int i = 0; i < 8; i++) tick();
    reset = 1'b1;
    #1;
    chk("abort_valid",    bus.lhs_valid, 1'b0);
    chk("abort_in_ready", bus.in_ready,  1'b1);
    chk("abort_nnz",      bus.nnz_total, '0);
    tick();
    reset = 1'b0;
    tick();
    run(0, "ident_after_rst");

    for (int t = 0; t < 6; t++) begin
      dens = $urandom_range(0, 100);
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          mat[r][c] = ($urandom_range(0, 99) < dens) ? data_t'($urandom_range(1, 255)) : '0;
      if (t == 0) mat[N-1][N-1] = 8'd0;
      run(1, $sformatf("rand%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
